// File: rtl/shooter_pixel_render.sv
// Shooting-game object state (ship, bullet, target, score), updated once per frame,
// plus a one-clock pixel pipeline that colours the scan from that state.
module shooter_pixel_render #(
    parameter int unsigned H_OFS       = 144,
    parameter int unsigned V_OFS       = 31,
    parameter int unsigned SHIP_Y      = 448,
    parameter int unsigned TARGET_Y    = 48,
    parameter int unsigned SHIP_STEP   = 4,
    parameter int unsigned BULLET_STEP = 8,
    parameter int unsigned TARGET_STEP = 2,
    parameter int unsigned HIT_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       video_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] score
);
    localparam int unsigned CW              = 10;
    localparam int unsigned HW              = $clog2(HIT_FRAMES + 1);
    localparam int unsigned SCREEN_W        = 640;
    localparam int unsigned SHIP_W          = 32;
    localparam int unsigned SHIP_H          = 16;
    localparam int unsigned TARGET_W        = 32;
    localparam int unsigned TARGET_H        = 16;
    localparam int unsigned BULLET_W        = 4;
    localparam int unsigned BULLET_H        = 8;
    localparam int unsigned SHIP_X_MAX      = SCREEN_W - SHIP_W;
    localparam int unsigned TARGET_X_MAX    = SCREEN_W - TARGET_W;
    localparam int unsigned SHIP_X_RST      = (SCREEN_W - SHIP_W) / 2;
    localparam int unsigned BULLET_X_OFS    = (SHIP_W - BULLET_W) / 2;
    localparam int unsigned BULLET_Y_LAUNCH = SHIP_Y - BULLET_H;

    localparam logic [7:0] COL_BULLET     = 8'hFC;
    localparam logic [7:0] COL_TARGET     = 8'hE0;
    localparam logic [7:0] COL_TARGET_HIT = 8'hFF;
    localparam logic [7:0] COL_SHIP       = 8'h1C;
    localparam logic [7:0] COL_BG         = 8'h00;

    typedef enum logic {B_IDLE, B_FLY}  bullet_state_t;
    typedef enum logic {T_MOVE, T_HIT}  target_state_t;

    bullet_state_t bullet_state, bullet_state_n;
    target_state_t target_state, target_state_n;
    logic [CW-1:0] ship_x, ship_x_n;
    logic [CW-1:0] bullet_x, bullet_x_n;
    logic [CW-1:0] bullet_y, bullet_y_n;
    logic [CW-1:0] target_x, target_x_n;
    logic          target_left, target_left_n;
    logic [HW-1:0] hit_cnt, hit_cnt_n;
    logic [7:0]    score_n;
    logic [7:0]    pixel;
    logic [CW-1:0] px, py;
    logic          frame_tick;
    logic          bullet_hits;

    // Point-in-rectangle test over [rx,rx+w) x [ry,ry+h)
    function automatic logic in_rect(input logic [CW-1:0] x, y, rx, ry, w, h);
        return (x >= rx) && (x < rx + w) && (y >= ry) && (y < ry + h);
    endfunction

    assign frame_tick = (hc == '0) && (vc == '0);
    assign px         = hc - CW'(H_OFS);
    assign py         = vc - CW'(V_OFS);

    assign bullet_hits = (bullet_state == B_FLY) && (target_state == T_MOVE)
        && (bullet_x < target_x + CW'(TARGET_W)) && (target_x < bullet_x + CW'(BULLET_W))
        && (bullet_y < CW'(TARGET_Y + TARGET_H)) && (CW'(TARGET_Y) < bullet_y + CW'(BULLET_H));

    // Per-frame next-state for ship, bullet FSM, target FSM and score
    always_comb begin
        ship_x_n       = ship_x;
        bullet_state_n = bullet_state;
        bullet_x_n     = bullet_x;
        bullet_y_n     = bullet_y;
        target_state_n = target_state;
        target_x_n     = target_x;
        target_left_n  = target_left;
        hit_cnt_n      = hit_cnt;
        score_n        = score;
        if (frame_tick) begin
            if (btn_left && !btn_right) begin
                ship_x_n = (ship_x < CW'(SHIP_STEP)) ? '0 : ship_x - CW'(SHIP_STEP);
            end else if (btn_right && !btn_left) begin
                ship_x_n = (ship_x > CW'(SHIP_X_MAX - SHIP_STEP)) ? CW'(SHIP_X_MAX)
                                                                  : ship_x + CW'(SHIP_STEP);
            end

            case (bullet_state)
                B_FLY: begin
                    if (bullet_hits) begin
                        bullet_state_n = B_IDLE;
                        score_n        = (score != 8'hFF) ? score + 8'd1 : score;
                    end else if (bullet_y < CW'(BULLET_STEP)) begin
                        bullet_state_n = B_IDLE;
                    end else begin
                        bullet_y_n = bullet_y - CW'(BULLET_STEP);
                    end
                end
                B_IDLE: begin
                    if (btn_fire) begin
                        bullet_state_n = B_FLY;
                        bullet_x_n     = ship_x + CW'(BULLET_X_OFS);
                        bullet_y_n     = CW'(BULLET_Y_LAUNCH);
                    end
                end
            endcase

            if (bullet_hits) begin
                target_state_n = T_HIT;
                hit_cnt_n      = HW'(HIT_FRAMES);
            end else begin
                case (target_state)
                    T_MOVE: begin
                        if (!target_left) begin
                            if (target_x >= CW'(TARGET_X_MAX - TARGET_STEP)) begin
                                target_x_n    = CW'(TARGET_X_MAX);
                                target_left_n = 1'b1;
                            end else begin
                                target_x_n = target_x + CW'(TARGET_STEP);
                            end
                        end else begin
                            if (target_x <= CW'(TARGET_STEP)) begin
                                target_x_n    = '0;
                                target_left_n = 1'b0;
                            end else begin
                                target_x_n = target_x - CW'(TARGET_STEP);
                            end
                        end
                    end
                    T_HIT: begin
                        if (hit_cnt <= HW'(1)) begin
                            target_state_n = T_MOVE;
                            hit_cnt_n      = '0;
                            target_x_n     = '0;
                            target_left_n  = 1'b0;
                        end else begin
                            hit_cnt_n = hit_cnt - HW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Pixel colour from the current scan position and registered object state
    always_comb begin
        pixel = COL_BG;
        if (video_in) begin
            if ((bullet_state == B_FLY) &&
                in_rect(px, py, bullet_x, bullet_y, CW'(BULLET_W), CW'(BULLET_H))) begin
                pixel = COL_BULLET;
            end else if (in_rect(px, py, target_x, CW'(TARGET_Y), CW'(TARGET_W), CW'(TARGET_H))) begin
                pixel = (target_state == T_HIT) ? COL_TARGET_HIT : COL_TARGET;
            end else if (in_rect(px, py, ship_x, CW'(SHIP_Y), CW'(SHIP_W), CW'(SHIP_H))) begin
                pixel = COL_SHIP;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!RESET) begin
            rgb          <= '0;
            hsync_out    <= 1'b1;
            vsync_out    <= 1'b1;
            score        <= '0;
            ship_x       <= CW'(SHIP_X_RST);
            bullet_state <= B_IDLE;
            bullet_x     <= '0;
            bullet_y     <= '0;
            target_state <= T_MOVE;
            target_x     <= '0;
            target_left  <= 1'b0;
            hit_cnt      <= '0;
        end else begin
            rgb          <= pixel;
            hsync_out    <= hsync_in;
            vsync_out    <= vsync_in;
            score        <= score_n;
            ship_x       <= ship_x_n;
            bullet_state <= bullet_state_n;
            bullet_x     <= bullet_x_n;
            bullet_y     <= bullet_y_n;
            target_state <= target_state_n;
            target_x     <= target_x_n;
            target_left  <= target_left_n;
            hit_cnt      <= hit_cnt_n;
        end
    end

endmodule
